demux16_deser: RTL and testbench
================================

# demux16_deser

Receive-side counterpart of the 16:1 mux serializer path. Accepts one bit per beat with a 4-bit lane select and writes it into lane `in_sel` of a 16-bit capture register. Once all 16 lanes have been written, it presents the reassembled word on a valid/ready output port. It sits after a `_16to1mux`-driven sweep and rebuilds the word that the mux serialized.

## Interface
Parameters:
- `CLEAR_ON_DRAIN`, default 1: 1 = capture register zeroed when a word is drained; 0 = register retains old bits until overwritten.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat present.
- `in_bit` in 1: serial data bit.
- `in_sel` in 4: destination lane, 0..15.
- `in_ready` out 1: block can accept a beat.
- `out_valid` out 1: `out_data` holds a complete word.
- `out_data` out 16: reassembled word; bit k = bit received with `in_sel`=k.
- `out_ready` in 1: downstream accepts word.
- `lane_mask` out 16: lanes written in the current frame.
- `dup_err` out 1: one-cycle pulse when a lane is written twice in one frame.
- `seq_err` out 1: one-cycle pulse on an out-of-order lane (see Configuration); constant 0 when the feature is compiled out.

## Operation
- Reset values: `in_ready`=0 during reset, then 1 after the first non-reset edge. `out_valid`=0, `out_data`=16'h0000, `lane_mask`=16'h0000, `dup_err`=0, `seq_err`=0. State is COLLECT.
- Two states: COLLECT and HOLD.
- COLLECT:
  - `in_ready`=1, `out_valid`=0.
  - A beat is accepted when `in_valid & in_ready`. On accept, `data[in_sel]`<=`in_bit` and `mask[in_sel]`<=1.
  - If `mask[in_sel]` was already 1: the bit is overwritten (last write wins), the mask is unchanged, and `dup_err` pulses.
  - If the accepted beat makes the mask 16'hFFFF, the next state is HOLD.
- HOLD:
  - `in_ready`=0, `out_valid`=1, `out_data` stable. `in_valid` is ignored and no bits are captured.
  - On `out_ready`=1: mask cleared to 0, data cleared to 0 if `CLEAR_ON_DRAIN`=1, next state COLLECT.
- `out_data` is always driven from the capture register; its value is only meaningful while `out_valid`=1.
- Lanes may arrive in any order (unless the ordering check is compiled in). Beats with `in_valid`=0 are no-ops, so gaps between beats are allowed.
- `rst` mid-frame or in HOLD discards the partial or complete word and returns all outputs to their reset values on that edge.

## Timing
- Capture latency: the bit is visible in `out_data`/`lane_mask` the cycle after the accepting edge.
- Word latency: if the 16th distinct lane is accepted at edge N, `out_valid`=1 from after edge N.
- Drain: when `out_valid & out_ready` at edge M, `out_valid`=0 and `in_ready`=1 after edge M. Minimum period is 17 cycles per word (16 beats + 1 drain cycle).
- `out_valid` must not drop without `out_ready`. `out_data` must not change while `out_valid`=1.
- `dup_err`/`seq_err` are high for exactly the cycle after the offending accept edge.
- No combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`; both are registered state decodes.

## Configuration
- `DEMUX16_ORDER_CHECK_EN`:
  - Defined: an internal 4-bit expected-lane counter starts at 0.
  - An accepted beat with `in_sel`==expected is captured, and the counter increments (wraps 15->0 on word completion).
  - An accepted beat with `in_sel`!=expected is not captured. It clears the mask and data (partial frame dropped), resets the counter to 0, and pulses `seq_err`.
  - Exception: if that beat has `in_sel`=0, it is captured as lane 0 of a new frame and the counter becomes 1.
  - Because lanes arrive in order, `dup_err` never fires in this mode.
- Undefined: the counter is absent, any order is accepted, and `seq_err` is tied 0.

## Test plan
- Ascending sweep: `in_sel`=0..15 carrying bits of 16'h30CF, `out_ready`=1 -> `out_valid` for one cycle with `out_data`=16'h30CF, 17 cycles total, no error pulses.
- Descending order 15..0 of 16'hA5A5 with the macro undefined -> `out_data`=16'hA5A5. With the macro defined -> `seq_err` pulses on `in_sel`=15 and on each beat after it up to `in_sel`=1. Those beats are dropped, `in_sel`=0 starts a new frame, and no word is output.
- Duplicate lane: write lane 3 =1, then lane 3 =0, then the other 15 lanes with 1s -> `dup_err` one pulse, `out_data`=16'hFFF7, `lane_mask` ends at 16'hFFFF.
- Backpressure: complete word 16'h1234 with `out_ready`=0 for 5 cycles, `in_valid`=1 with random bits -> `in_ready`=0, `out_data` stays 16'h1234. Raise `out_ready` -> next cycle `out_valid`=0, `in_ready`=1, `lane_mask`=0.
- Reset mid-frame: 8 lanes written, then `rst`=1 for one cycle -> `lane_mask`=0, `out_data`=0, `out_valid`=0. A following full sweep of 16'h30CF outputs 16'h30CF.
- `CLEAR_ON_DRAIN`=0: drain 16'hFFFF, then write only lanes 0..14 with 0 -> `lane_mask`=16'h7FFF, `out_data`=16'h8000, `out_valid`=0.

Source files
------------

// File: rtl/demux16_deser.sv
// ---------------------------------------------------------------------------
// demux16_deser
//
// Receive-side 1:16 deserializer. Each accepted beat carries one bit together
// with the lane it belongs to. The bit is written into that lane of a 16-bit
// capture register. Once all 16 lanes of a frame have been written, the
// reassembled word is offered on a valid/ready output port.
//
// Parameters:
//   CLEAR_ON_DRAIN  1: capture register zeroed when a word is drained
//                   0: capture register keeps old bits until overwritten
//
// Optional feature (compile-time macro):
//   DEMUX16_ORDER_CHECK_EN  When defined, lanes must arrive in order 0..15.
//                           An out-of-order beat drops the partial frame and
//                           pulses seq_err. When undefined, any lane order is
//                           accepted and seq_err is tied low.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   input beat present
//   in_bit     in   1   serial data bit
//   in_sel     in   4   destination lane 0..15
//   in_ready   out  1   block can accept a beat (registered)
//   out_valid  out  1   out_data holds a complete word (registered)
//   out_data   out  16  capture register; bit k came from in_sel==k
//   out_ready  in   1   downstream accepts the word
//   lane_mask  out  16  lanes written in the current frame
//   dup_err    out  1   one-cycle pulse: lane written twice in one frame
//   seq_err    out  1   one-cycle pulse: out-of-order lane (order check only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module demux16_deser #(
  parameter int unsigned CLEAR_ON_DRAIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic [3:0]  in_sel,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [15:0] lane_mask,
  output logic        dup_err,
  output logic        seq_err
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  logic [0:0]  state_reg, state_next;
  logic [15:0] data_reg, data_next;
  logic [15:0] mask_reg, mask_next;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic        dup_err_reg, dup_err_next;
  logic        accept;
  logic [15:0] sel_onehot;
  logic [15:0] bit_onehot;

  // One-hot decode of the destination lane, and the same decode qualified
  // with the incoming bit, so capture becomes a pure bitwise merge.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_lane_dec
      assign sel_onehot[gi] = (in_sel == gi[3:0]);
      assign bit_onehot[gi] = (in_sel == gi[3:0]) & in_bit;
    end
  endgenerate

  // in_ready_reg is only ever high in COLLECT, so it alone qualifies accept.
  assign accept = in_valid & in_ready_reg;

`ifdef DEMUX16_ORDER_CHECK_EN
  logic [3:0] exp_reg, exp_next;
  logic       seq_err_reg, seq_err_next;
`endif

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    mask_next    = mask_reg;
    dup_err_next = 1'b0;
`ifdef DEMUX16_ORDER_CHECK_EN
    exp_next     = exp_reg;
    seq_err_next = 1'b0;
`endif
    case (state_reg)
      ST_COLLECT: begin
        if (accept) begin
`ifdef DEMUX16_ORDER_CHECK_EN
          if (in_sel == exp_reg) begin
            data_next    = (data_reg & ~sel_onehot) | bit_onehot;
            mask_next    = mask_reg | sel_onehot;
            dup_err_next = |(mask_reg & sel_onehot);
            // 15 -> 0 wrap coincides with word completion.
            exp_next     = exp_reg + 4'd1;
          end else begin
            // Partial frame is dropped. A lane-0 beat doubles as the start
            // of a fresh frame instead of being thrown away.
            seq_err_next = 1'b1;
            if (in_sel == 4'd0) begin
              data_next = {15'h0000, in_bit};
              mask_next = 16'h0001;
              exp_next  = 4'd1;
            end else begin
              data_next = 16'h0000;
              mask_next = 16'h0000;
              exp_next  = 4'd0;
            end
          end
`else
          // Last write wins on a repeated lane; the mask bit is already set.
          data_next    = (data_reg & ~sel_onehot) | bit_onehot;
          mask_next    = mask_reg | sel_onehot;
          dup_err_next = |(mask_reg & sel_onehot);
`endif
          if (&mask_next) begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          mask_next  = 16'h0000;
          state_next = ST_COLLECT;
          if (CLEAR_ON_DRAIN != 0) begin
            data_next = 16'h0000;
          end
        end
      end
      default: begin
        state_next = ST_COLLECT;
      end
    endcase
  end

  // Handshake outputs are registered decodes of the next state, so there is
  // no combinational path from in_valid/out_ready to in_ready/out_valid.
  // in_ready stays low on the reset edge and rises on the first free edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_COLLECT;
      data_reg      <= 16'h0000;
      mask_reg      <= 16'h0000;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      dup_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      mask_reg      <= mask_next;
      in_ready_reg  <= (state_next == ST_COLLECT);
      out_valid_reg <= (state_next == ST_HOLD);
      dup_err_reg   <= dup_err_next;
    end
  end

`ifdef DEMUX16_ORDER_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_reg     <= 4'd0;
      seq_err_reg <= 1'b0;
    end else begin
      exp_reg     <= exp_next;
      seq_err_reg <= seq_err_next;
    end
  end
  assign seq_err = seq_err_reg;
`else
  assign seq_err = 1'b0;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = data_reg;
  assign lane_mask = mask_reg;
  assign dup_err   = dup_err_reg;

endmodule

// File: tb/tb_demux16_deser.sv
// ---------------------------------------------------------------------------
// tb_demux16_deser
//
// Directed bench for demux16_deser. Two instances: u0 with CLEAR_ON_DRAIN=1
// and u1 with CLEAR_ON_DRAIN=0. Expected words are pushed into a queue per
// instance when a frame is issued; a monitor pops and compares on every
// out_valid & out_ready handshake and counts error pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_demux16_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid0 = 1'b0, in_bit0 = 1'b0, out_ready0 = 1'b0;
  logic [3:0]  in_sel0 = 4'd0;
  logic        in_ready0, out_valid0, dup_err0, seq_err0;
  logic [15:0] out_data0, lane_mask0;

  logic        in_valid1 = 1'b0, in_bit1 = 1'b0, out_ready1 = 1'b0;
  logic [3:0]  in_sel1 = 4'd0;
  logic        in_ready1, out_valid1, dup_err1, seq_err1;
  logic [15:0] out_data1, lane_mask1;

  int n_cmp = 0;
  int n_bad = 0;
  int dup_cnt = 0;
  int seq_cnt = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  demux16_deser #(.CLEAR_ON_DRAIN(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_bit(in_bit0),
    .in_sel(in_sel0), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_data(out_data0), .out_ready(out_ready0), .lane_mask(lane_mask0),
    .dup_err(dup_err0), .seq_err(seq_err0)
  );

  demux16_deser #(.CLEAR_ON_DRAIN(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_bit(in_bit1),
    .in_sel(in_sel1), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_ready(out_ready1), .lane_mask(lane_mask1),
    .dup_err(dup_err1), .seq_err(seq_err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Scoreboard monitors: one line per drained word.
  always @(negedge clk) begin
    if (dup_err0 || dup_err1) dup_cnt++;
    if (seq_err0 || seq_err1) seq_cnt++;
    if (out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL word0_unexpected: got %0h expected none", out_data0);
      end else begin
        check("word0", {16'h0, out_data0}, {16'h0, q0.pop_front()});
      end
    end
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL word1_unexpected: got %0h expected none", out_data1);
      end else begin
        check("word1", {16'h0, out_data1}, {16'h0, q1.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat occupies one cycle; inputs change 1 ns after the rising edge.
  task automatic beat(input int inst, input logic [3:0] sel, input logic b);
    if (inst == 0) begin
      in_valid0 = 1'b1; in_sel0 = sel; in_bit0 = b;
    end else begin
      in_valid1 = 1'b1; in_sel1 = sel; in_bit1 = b;
    end
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int d0, s0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", {31'h0, in_ready0}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid0}, 32'h0);
    check("rst_out_data", {16'h0, out_data0}, 32'h0);
    check("rst_lane_mask", {16'h0, lane_mask0}, 32'h0);
    check("rst_errs", {30'h0, dup_err0, seq_err0}, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {30'h0, in_ready0, in_ready1}, 32'h3);

    // Ascending sweep 30CF, drain immediately
    d0 = dup_cnt; s0 = seq_cnt;
    out_ready0 = 1'b1;
    w = 16'h30CF;
    q0.push_back(w);
    for (int i = 0; i < 16; i++) begin
      beat(0, i[3:0], w[i]);
      if (i == 7) check("asc_mask_half", {16'h0, lane_mask0}, 32'h00FF);
    end
    check("asc_out_valid", {31'h0, out_valid0}, 32'h1);
    check("asc_in_ready_low", {31'h0, in_ready0}, 32'h0);
    tick();
    check("asc_drained_valid", {31'h0, out_valid0}, 32'h0);
    check("asc_drained_ready", {31'h0, in_ready0}, 32'h1);
    check("asc_cleared_mask", {16'h0, lane_mask0}, 32'h0);
    check("asc_cleared_data", {16'h0, out_data0}, 32'h0);
    check("asc_no_dup", dup_cnt - d0, 32'h0);
    check("asc_no_seq", seq_cnt - s0, 32'h0);

    // Descending sweep A5A5
    d0 = dup_cnt; s0 = seq_cnt;
    w = 16'hA5A5;
`ifdef DEMUX16_ORDER_CHECK_EN
    for (int i = 15; i >= 0; i--) beat(0, i[3:0], w[i]);
    check("desc_seq_pulses", seq_cnt - s0, 32'd15);
    check("desc_mask_restart", {16'h0, lane_mask0}, 32'h0001);
    check("desc_no_word", {31'h0, out_valid0}, 32'h0);
    do_reset();
`else
    q0.push_back(w);
    for (int i = 15; i >= 0; i--) beat(0, i[3:0], w[i]);
    check("desc_out_valid", {31'h0, out_valid0}, 32'h1);
    tick();
    check("desc_no_seq", seq_cnt - s0, 32'h0);
    check("desc_no_dup", dup_cnt - d0, 32'h0);

    // Duplicate lane 3: 1 then 0, all other lanes 1
    d0 = dup_cnt;
    out_ready0 = 1'b0;
    q0.push_back(16'hFFF7);
    beat(0, 4'd3, 1'b1);
    beat(0, 4'd3, 1'b0);
    check("dup_mask_after_repeat", {16'h0, lane_mask0}, 32'h0008);
    for (int i = 0; i < 16; i++) begin
      if (i != 3) beat(0, i[3:0], 1'b1);
    end
    check("dup_pulse_count", dup_cnt - d0, 32'd1);
    check("dup_mask_full", {16'h0, lane_mask0}, 32'hFFFF);
    check("dup_out_valid", {31'h0, out_valid0}, 32'h1);
    out_ready0 = 1'b1;
    tick();
`endif

    // Backpressure: 1234 held for 5 cycles with in_valid=1
    out_ready0 = 1'b0;
    w = 16'h1234;
    q0.push_back(w);
    for (int i = 0; i < 16; i++) beat(0, i[3:0], w[i]);
    for (int c = 0; c < 5; c++) begin
      in_valid0 = 1'b1;
      in_sel0 = 4'($urandom_range(0, 15));
      in_bit0 = 1'($urandom);
      tick();
      check("bp_in_ready", {31'h0, in_ready0}, 32'h0);
      check("bp_out_valid", {31'h0, out_valid0}, 32'h1);
      check("bp_out_data", {16'h0, out_data0}, 32'h1234);
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    tick();
    check("bp_drain_valid", {31'h0, out_valid0}, 32'h0);
    check("bp_drain_ready", {31'h0, in_ready0}, 32'h1);
    check("bp_drain_mask", {16'h0, lane_mask0}, 32'h0);

    // Reset mid-frame
    w = 16'h30CF;
    for (int i = 0; i < 8; i++) beat(0, i[3:0], w[i]);
    check("mid_mask_before", {16'h0, lane_mask0}, 32'h00FF);
    rst = 1'b1;
    tick();
    check("mid_rst_mask", {16'h0, lane_mask0}, 32'h0);
    check("mid_rst_data", {16'h0, out_data0}, 32'h0);
    check("mid_rst_valid", {31'h0, out_valid0}, 32'h0);
    rst = 1'b0;
    tick();
    q0.push_back(w);
    for (int i = 0; i < 16; i++) beat(0, i[3:0], w[i]);
    check("mid_full_valid", {31'h0, out_valid0}, 32'h1);
    tick();

    // CLEAR_ON_DRAIN=0 instance
    out_ready1 = 1'b1;
    q1.push_back(16'hFFFF);
    for (int i = 0; i < 16; i++) beat(1, i[3:0], 1'b1);
    check("cod0_valid", {31'h0, out_valid1}, 32'h1);
    tick();
    check("cod0_data_kept", {16'h0, out_data1}, 32'hFFFF);
    for (int i = 0; i < 15; i++) beat(1, i[3:0], 1'b0);
    check("cod0_mask", {16'h0, lane_mask1}, 32'h7FFF);
    check("cod0_data", {16'h0, out_data1}, 32'h8000);
    check("cod0_no_valid", {31'h0, out_valid1}, 32'h0);

    tick(); tick();
    check("q0_drained", q0.size(), 32'h0);
    check("q1_drained", q1.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
